grf_mp: RTL and testbench

- Parametrised multi-port general register file for the pipelined CPU. Successor to the single-write, two-read GRF.
- Provides NR read ports with write-through forwarding and NW prioritised write ports.
- Keeps a per-register pending scoreboard (busy bits) so decode can detect RAW hazards on results still in flight.
- Sits between decode (read and issue) and the writeback stage(s).

---
 rtl/grf_pkg.sv | 21 ++
 rtl/grf_scoreboard.sv | 69 ++++++
 rtl/grf_mp.sv | 134 +++++++++++++
 tb/tb_grf_mp.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/grf_pkg.sv
// grf_pkg
// Shared constants for the multi-port general register file and the
// helper that derives the address width from the register count.
//   DW_DEFAULT     default data width in bits
//   DEPTH_DEFAULT  default number of registers (power of 2)
//   NR_DEFAULT     default number of read ports
//   NW_DEFAULT     default number of write ports
//   addrWidth()    address width for a given register count
package grf_pkg;

  localparam int DW_DEFAULT    = 32;
  localparam int DEPTH_DEFAULT = 32;
  localparam int NR_DEFAULT    = 2;
  localparam int NW_DEFAULT    = 2;

  // A single-entry file still needs a one-bit address to keep port widths legal.
  function automatic int addrWidth(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/grf_scoreboard.sv
// grf_scoreboard
// Per-register pending bits used by decode to detect RAW hazards on results
// that have been issued but not yet written back.
//   clk, rst      clock and synchronous active-high reset
//   issValid_i    issue strobe, marks issAddr_i pending
//   issAddr_i     destination register of the issuing instruction
//   wrEff_i       effective (non-suppressed) write enables, one per write port
//   wrAddr_i      write addresses, port j in slice j
//   rdAddr_i      read addresses, port i in slice i
//   rdBusy_o      pending bit per read port, masked by same-cycle writeback
//   busyVec_o     registered pending bits
module grf_scoreboard #(
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter int NR       = 2,
  parameter int NW       = 2,
  parameter int ZERO_REG = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issValid_i,
  input  logic [AW-1:0]    issAddr_i,
  input  logic [NW-1:0]    wrEff_i,
  input  logic [NW*AW-1:0] wrAddr_i,
  input  logic [NR*AW-1:0] rdAddr_i,
  output logic [NR-1:0]    rdBusy_o,
  output logic [DEPTH-1:0] busyVec_o
);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic [DEPTH-1:0] setVec;
  logic [DEPTH-1:0] clrVec;

  // Issue wins over writeback so a newer issue re-arms a bit that an older
  // result is clearing in the same cycle.
  always_comb begin
    setVec = '0;
    clrVec = '0;
    for (int r = 0; r < DEPTH; r++) begin
      setVec[r] = issValid_i && (issAddr_i == AW'(r)) && !((ZERO_REG != 0) && (r == 0));
    end
    for (int j = 0; j < NW; j++) begin
      if (wrEff_i[j]) begin
        clrVec[wrAddr_i[j*AW +: AW]] = 1'b1;
      end
    end
    busy_d = setVec | (busy_q & ~clrVec);
  end

  // A result written back this cycle is forwarded, so it is not reported busy.
  always_comb begin
    rdBusy_o = '0;
    for (int i = 0; i < NR; i++) begin
      rdBusy_o[i] = busy_q[rdAddr_i[i*AW +: AW]] & ~clrVec[rdAddr_i[i*AW +: AW]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busyVec_o = busy_q;

endmodule

// File: rtl/grf_mp.sv
// grf_mp
// Parametrised multi-port general register file with write-through
// forwarding, prioritised write ports (highest index wins) and a pending
// scoreboard for RAW hazard detection.
// Optional feature: define GRF_TRACE_EN to print one line per stored write.
//   clk, rst   clock and synchronous active-high reset
//   rd_addr    read addresses, port i in slice i
//   rd_data    combinational forwarded read data
//   rd_busy    combinational pending bit per read port
//   iss_valid  issue strobe, iss_addr = destination register
//   wr_en      write enables, wr_addr / wr_data / wr_pc per port
//   busy_vec   registered scoreboard state
module grf_mp
  import grf_pkg::*;
#(
  parameter int DW       = DW_DEFAULT,
  parameter int DEPTH    = DEPTH_DEFAULT,
  parameter int NR       = NR_DEFAULT,
  parameter int NW       = NW_DEFAULT,
  parameter int ZERO_REG = 1,
  localparam int AW      = addrWidth(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NR*AW-1:0] rd_addr,
  output logic [NR*DW-1:0] rd_data,
  output logic [NR-1:0]    rd_busy,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_addr,
  input  logic [NW-1:0]    wr_en,
  input  logic [NW*AW-1:0] wr_addr,
  input  logic [NW*DW-1:0] wr_data,
  input  logic [NW*32-1:0] wr_pc,
  output logic [DEPTH-1:0] busy_vec
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [NW-1:0] wrEff;

  // Writes to the hardwired zero register are suppressed everywhere.
  always_comb begin
    wrEff = '0;
    for (int j = 0; j < NW; j++) begin
      wrEff[j] = wr_en[j] && !((ZERO_REG != 0) && (wr_addr[j*AW +: AW] == '0));
    end
  end

  // Ascending port order lets the highest-index port overwrite lower ones.
  always_comb begin
    mem_d = mem_q;
    for (int j = 0; j < NW; j++) begin
      if (wrEff[j]) begin
        mem_d[wr_addr[j*AW +: AW]] = wr_data[j*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        mem_q[r] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Same-cycle writes bypass the array, again highest index last.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NR; i++) begin
      rd_data[i*DW +: DW] = mem_q[rd_addr[i*AW +: AW]];
      for (int j = 0; j < NW; j++) begin
        if (wrEff[j] && (wr_addr[j*AW +: AW] == rd_addr[i*AW +: AW])) begin
          rd_data[i*DW +: DW] = wr_data[j*DW +: DW];
        end
      end
      if ((ZERO_REG != 0) && (rd_addr[i*AW +: AW] == '0)) begin
        rd_data[i*DW +: DW] = '0;
      end
    end
  end

  grf_scoreboard #(
    .DEPTH    (DEPTH),
    .AW       (AW),
    .NR       (NR),
    .NW       (NW),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .issValid_i (iss_valid),
    .issAddr_i  (iss_addr),
    .wrEff_i    (wrEff),
    .wrAddr_i   (wr_addr),
    .rdAddr_i   (rd_addr),
    .rdBusy_o   (rd_busy),
    .busyVec_o  (busy_vec)
  );

`ifdef GRF_TRACE_EN
  logic [NW-1:0] wrWins;

  // A write is traced only if no higher-index port hits the same address.
  always_comb begin
    wrWins = wrEff;
    for (int j = 0; j < NW; j++) begin
      for (int k = j + 1; k < NW; k++) begin
        if (wrEff[k] && (wr_addr[k*AW +: AW] == wr_addr[j*AW +: AW])) begin
          wrWins[j] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int j = 0; j < NW; j++) begin
        if (wrWins[j]) begin
          $display("%0t@%h: $%0d <= %h", $time, wr_pc[j*32 +: 32],
                   wr_addr[j*AW +: AW], wr_data[j*DW +: DW]);
        end
      end
    end
  end
`else
  // The PC is only consumed by the trace.
  logic unusedPc;
  assign unusedPc = ^wr_pc;
`endif

endmodule

// File: tb/tb_grf_mp.sv
// tb_grf_mp
// Directed bench for grf_mp with default parameters. Each stimulus cycle
// queues its hand-computed expectations; a monitor pops and compares them
// on the falling edge of the same cycle.
module tb_grf_mp;

  logic        clk;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        iss_valid;
  logic [4:0]  iss_addr;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic [63:0] wr_pc;
  logic [31:0] busy_vec;

  int checks = 0;
  int errors = 0;

  localparam int K_DATA = 0;
  localparam int K_BUSY = 1;
  localparam int K_VEC  = 2;

  typedef struct {
    string       name;
    int          kind;
    int          port;
    logic [31:0] exp;
  } expect_t;

  expect_t expQ[$];

  grf_mp dut (
    .clk       (clk),
    .rst       (rst),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_pc     (wr_pc),
    .busy_vec  (busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one cycle of inputs just after the rising edge.
  task automatic applyStimulus(input logic r, input logic iv, input logic [4:0] ia,
                               input logic [1:0] we,
                               input logic [4:0] wa0, input logic [31:0] wd0,
                               input logic [4:0] wa1, input logic [31:0] wd1,
                               input logic [4:0] ra0, input logic [4:0] ra1);
    @(posedge clk);
    #1;
    rst       = r;
    iss_valid = iv;
    iss_addr  = ia;
    wr_en     = we;
    wr_addr   = {wa1, wa0};
    wr_data   = {wd1, wd0};
    wr_pc     = wr_pc + 64'h0000_0004_0000_0004;
    rd_addr   = {ra1, ra0};
  endtask

  task automatic idle(input logic [4:0] ra0, input logic [4:0] ra1);
    applyStimulus(1'b0, 1'b0, 5'd0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, ra0, ra1);
  endtask

  task automatic expectVal(input string name, input int kind, input int port,
                           input logic [31:0] exp);
    expect_t e;
    e.name = name;
    e.kind = kind;
    e.port = port;
    e.exp  = exp;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input expect_t e);
    logic [31:0] act;
    case (e.kind)
      K_DATA:  act = rd_data[e.port*32 +: 32];
      K_BUSY:  act = {31'b0, rd_busy[e.port]};
      default: act = busy_vec;
    endcase
    checks++;
    if (act !== e.exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", e.name, act, e.exp);
    end
  endtask

  // Monitor: outputs are combinational or registered, so every queued
  // expectation is due on the falling edge of the cycle that queued it.
  initial begin
    expect_t e;
    forever begin
      @(negedge clk);
      while (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; iss_valid = 1'b0; iss_addr = '0; wr_en = '0;
    wr_addr = '0; wr_data = '0; wr_pc = 64'h0000_1000_0000_2000; rd_addr = '0;

    applyStimulus(1'b1, 1'b0, 5'd0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0);
    applyStimulus(1'b1, 1'b0, 5'd0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0);

    // Reset state
    idle(5'd5, 5'd5);
    expectVal("rst_data0", K_DATA, 0, 32'h0);
    expectVal("rst_data1", K_DATA, 1, 32'h0);
    expectVal("rst_busy0", K_BUSY, 0, 32'h0);
    expectVal("rst_busy1", K_BUSY, 1, 32'h0);
    expectVal("rst_vec",   K_VEC,  0, 32'h0);

    // Forwarding then array read
    applyStimulus(1'b0, 1'b0, 5'd0, 2'b01, 5'd3, 32'h1234, 5'd0, 32'h0, 5'd3, 5'd0);
    expectVal("fwd_r3", K_DATA, 0, 32'h1234);
    idle(5'd3, 5'd3);
    expectVal("arr_r3_p0", K_DATA, 0, 32'h1234);
    expectVal("arr_r3_p1", K_DATA, 1, 32'h1234);

    // Write priority on a shared address
    applyStimulus(1'b0, 1'b0, 5'd0, 2'b11, 5'd7, 32'hAAAA, 5'd7, 32'h5555, 5'd7, 5'd3);
    expectVal("prio_fwd_r7", K_DATA, 0, 32'h5555);
    expectVal("prio_r3",     K_DATA, 1, 32'h1234);
    idle(5'd7, 5'd0);
    expectVal("prio_arr_r7", K_DATA, 0, 32'h5555);

    // Port 1 alone, port 0 disabled with conflicting data
    applyStimulus(1'b0, 1'b0, 5'd0, 2'b10, 5'd8, 32'hDEAD, 5'd8, 32'hBEEF, 5'd0, 5'd8);
    expectVal("p1_fwd_r8", K_DATA, 1, 32'hBEEF);
    idle(5'd8, 5'd0);
    expectVal("p1_arr_r8", K_DATA, 0, 32'hBEEF);

    // Zero register
    applyStimulus(1'b0, 1'b1, 5'd0, 2'b01, 5'd0, 32'hFFFF, 5'd0, 32'h0, 5'd0, 5'd0);
    expectVal("r0_fwd",  K_DATA, 0, 32'h0);
    expectVal("r0_vec",  K_VEC,  0, 32'h0);
    idle(5'd0, 5'd0);
    expectVal("r0_arr",  K_DATA, 0, 32'h0);
    expectVal("r0_busy", K_BUSY, 0, 32'h0);
    expectVal("r0_vec2", K_VEC,  0, 32'h0);

    // Scoreboard: issue, writeback, re-arm
    applyStimulus(1'b0, 1'b1, 5'd9, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd0);
    expectVal("iss_same_busy", K_BUSY, 0, 32'h0);
    expectVal("iss_same_vec",  K_VEC,  0, 32'h0);
    idle(5'd9, 5'd0);
    expectVal("iss_busy", K_BUSY, 0, 32'h1);
    expectVal("iss_vec",  K_VEC,  0, 32'h0000_0200);
    applyStimulus(1'b0, 1'b0, 5'd0, 2'b01, 5'd9, 32'h99, 5'd0, 32'h0, 5'd9, 5'd0);
    expectVal("wb_busy", K_BUSY, 0, 32'h0);
    expectVal("wb_data", K_DATA, 0, 32'h99);
    expectVal("wb_vec",  K_VEC,  0, 32'h0000_0200);
    idle(5'd9, 5'd0);
    expectVal("clr_busy", K_BUSY, 0, 32'h0);
    expectVal("clr_vec",  K_VEC,  0, 32'h0);
    applyStimulus(1'b0, 1'b1, 5'd9, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd9);
    expectVal("reiss_vec", K_VEC, 0, 32'h0);
    applyStimulus(1'b0, 1'b1, 5'd9, 2'b10, 5'd0, 32'h0, 5'd9, 32'h9A, 5'd0, 5'd9);
    expectVal("rearm_vec",  K_VEC,  0, 32'h0000_0200);
    expectVal("rearm_busy", K_BUSY, 1, 32'h0);
    expectVal("rearm_data", K_DATA, 1, 32'h9A);
    idle(5'd0, 5'd9);
    expectVal("rearm_busy2", K_BUSY, 1, 32'h1);
    expectVal("rearm_vec2",  K_VEC,  0, 32'h0000_0200);
    expectVal("rearm_data2", K_DATA, 1, 32'h9A);

    // Reset mid-operation
    applyStimulus(1'b0, 1'b1, 5'd4, 2'b01, 5'd4, 32'h77, 5'd0, 32'h0, 5'd4, 5'd0);
    expectVal("r4_fwd", K_DATA, 0, 32'h77);
    idle(5'd4, 5'd0);
    expectVal("r4_arr",  K_DATA, 0, 32'h77);
    expectVal("r4_busy", K_BUSY, 0, 32'h1);
    expectVal("r4_vec",  K_VEC,  0, 32'h0000_0210);
    applyStimulus(1'b1, 1'b1, 5'd5, 2'b01, 5'd4, 32'h55, 5'd0, 32'h0, 5'd4, 5'd9);
    idle(5'd4, 5'd9);
    expectVal("mrst_r4",    K_DATA, 0, 32'h0);
    expectVal("mrst_r9",    K_DATA, 1, 32'h0);
    expectVal("mrst_busy0", K_BUSY, 0, 32'h0);
    expectVal("mrst_busy1", K_BUSY, 1, 32'h0);
    expectVal("mrst_vec",   K_VEC,  0, 32'h0);

    // Writes after reset still land
    applyStimulus(1'b0, 1'b0, 5'd0, 2'b01, 5'd4, 32'h42, 5'd0, 32'h0, 5'd4, 5'd0);
    expectVal("post_fwd", K_DATA, 0, 32'h42);
    idle(5'd4, 5'd0);
    expectVal("post_arr", K_DATA, 0, 32'h42);
    expectVal("post_vec", K_VEC,  0, 32'h0);

    idle(5'd0, 5'd0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL queue_drain: got %0d pending expected 0", expQ.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
